// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake for the UART transmitter FIFO.
// The producer holds TxData/TxValid until the FIFO raises TxReady.
interface uart_tx_fifo_if;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;

    modport master (output TxData, output TxValid, input TxReady);
    modport slave  (input TxData, input TxValid, output TxReady);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO, returning result/status bytes to the host.
// Queued frames are sent back to back with no idle gap between stop and next start bit.
module uart_tx_fifo #(
    parameter int W5Frequency = 6_250_000,
    parameter int baudRate    = 128_000,
    parameter int bitCycles   = W5Frequency / baudRate + 1,
    parameter int fifoDepth   = 4,
    localparam int countWidth = $clog2(fifoDepth) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_fifo_if.slave         tx,
    output logic                  TxD,
    output logic                  busy,
    output logic                  txDone,
    output logic [countWidth-1:0] fifoCount
);

    localparam int ptrWidth     = $clog2(fifoDepth);
    localparam int counterWidth = $clog2(bitCycles);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState;

    txState                  state, nextState;
    logic [7:0]              mem [fifoDepth];
    logic [ptrWidth-1:0]     wrPtr, rdPtr;
    logic [countWidth-1:0]   count;
    logic [7:0]              shiftReg, nextShift;
    logic [counterWidth-1:0] bitCounter, nextBitCounter;
    logic [2:0]              bitIndex, nextBitIndex;
    logic                    nextTxd, nextTxDone;
    logic                    push, pop, periodEnd;

    // Ready comes from the registered count only, so a full FIFO refuses a push even while popping.
    assign tx.TxReady = (count < countWidth'(fifoDepth));
    assign push       = tx.TxValid && tx.TxReady;
    assign periodEnd  = (bitCounter == counterWidth'(bitCycles - 1));
    assign busy       = (state != IDLE);
    assign fifoCount  = count;

    always_comb begin
        nextState      = state;
        nextTxd        = TxD;
        nextShift      = shiftReg;
        nextBitCounter = bitCounter + 1'b1;
        nextBitIndex   = bitIndex;
        nextTxDone     = 1'b0;
        pop            = 1'b0;
        case (state)
            IDLE: begin
                nextTxd        = 1'b1;
                nextBitCounter = '0;
                if (count != '0) begin
                    pop       = 1'b1;
                    nextShift = mem[rdPtr];
                    nextTxd   = 1'b0;
                    nextState = START;
                end
            end
            START: begin
                if (periodEnd) begin
                    nextBitCounter = '0;
                    nextBitIndex   = '0;
                    nextTxd        = shiftReg[0];
                    nextState      = DATA;
                end
            end
            DATA: begin
                if (periodEnd) begin
                    nextBitCounter = '0;
                    nextShift      = {1'b0, shiftReg[7:1]};
                    if (bitIndex == 3'd7) begin
                        nextTxd   = 1'b1;
                        nextState = STOP;
                    end else begin
                        nextBitIndex = bitIndex + 1'b1;
                        nextTxd      = shiftReg[1];
                    end
                end
            end
            STOP: begin
                if (periodEnd) begin
                    nextBitCounter = '0;
                    nextTxDone     = 1'b1;
                    if (count != '0) begin
                        pop       = 1'b1;
                        nextShift = mem[rdPtr];
                        nextTxd   = 1'b0;
                        nextState = START;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: begin
                nextTxd   = 1'b1;
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            TxD        <= 1'b1;
            txDone     <= 1'b0;
            shiftReg   <= '0;
            bitCounter <= '0;
            bitIndex   <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
        end else begin
            state      <= nextState;
            TxD        <= nextTxd;
            txDone     <= nextTxDone;
            shiftReg   <= nextShift;
            bitCounter <= nextBitCounter;
            bitIndex   <= nextBitIndex;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= tx.TxData;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a frame-level queue model predicts the line every cycle,
// and a bit-centre serial decoder checks the bytes arrive in push order.
module tb_uart_tx_fifo;

    localparam int bitCycles   = 49;
    localparam int frameCycles = 10 * bitCycles;
    localparam int fifoDepth   = 4;

    logic       clk;
    logic       reset;
    logic       TxD, busy, txDone;
    logic [2:0] fifoCount;

    uart_tx_fifo_if txBus ();

    uart_tx_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .tx        (txBus),
        .TxD       (TxD),
        .busy      (busy),
        .txDone    (txDone),
        .fifoCount (fifoCount)
    );

    int   testsRun = 0;
    int   failCount = 0;
    bit   checkOn = 0;
    int   cycleCount = 0;
    int   resetEpoch = 0;
    int   framesDecoded = 0;
    int   lastPushCycle = 0;
    logic [7:0] sentQ [$];
    int   doneCycles [$];

    logic [7:0] modelQ [$];
    bit         modelBusy = 0;
    bit         modelDone = 0;
    logic [7:0] modelByte = '0;
    int         modelElapsed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", tag, observed, expected, cycleCount);
        end
    endtask

    function automatic logic expectedTxd();
        int k;
        if (!modelBusy) return 1'b1;
        k = modelElapsed / bitCycles;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return modelByte[k-1];
    endfunction

    initial forever begin
        @(posedge clk);
        cycleCount++;
    end

    initial forever begin
        @(posedge reset);
        resetEpoch++;
    end

    // Frame-level model: a byte queue plus the age of the frame on the line.
    initial begin : model
        bit accept;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                modelQ.delete();
                modelBusy    = 0;
                modelDone    = 0;
                modelElapsed = 0;
            end else begin
                accept    = (txBus.TxValid === 1'b1) && (modelQ.size() < fifoDepth);
                modelDone = 0;
                if (modelBusy) begin
                    modelElapsed++;
                    if (modelElapsed == frameCycles) begin
                        modelBusy = 0;
                        modelDone = 1;
                    end
                end
                if (!modelBusy && modelQ.size() > 0) begin
                    modelByte    = modelQ.pop_front();
                    modelBusy    = 1;
                    modelElapsed = 0;
                end
                if (accept) modelQ.push_back(txBus.TxData);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (checkOn) begin
            checkOutput("TxD", TxD, expectedTxd());
            checkOutput("busy", busy, modelBusy);
            checkOutput("txDone", txDone, modelDone);
            checkOutput("fifoCount", fifoCount, modelQ.size());
            checkOutput("TxReady", txBus.TxReady, modelQ.size() < fifoDepth);
            if (txDone === 1'b1) doneCycles.push_back(cycleCount);
        end
    end

    // Independent receiver: samples each bit at its centre after the falling start edge.
    initial begin : serialDecoder
        logic [7:0] rxByte;
        logic       startBit, stopBit;
        int         epoch;
        forever begin
            @(negedge clk);
            if (checkOn && !reset && TxD === 1'b0) begin
                epoch  = resetEpoch;
                rxByte = '0;
                repeat (bitCycles / 2) @(negedge clk);
                startBit = TxD;
                for (int i = 0; i < 8; i++) begin
                    repeat (bitCycles) @(negedge clk);
                    rxByte[i] = TxD;
                end
                repeat (bitCycles) @(negedge clk);
                stopBit = TxD;
                if (epoch == resetEpoch && !reset) begin
                    checkOutput("startBit", startBit, 1'b0);
                    checkOutput("stopBit", stopBit, 1'b1);
                    checkOutput("frameExpected", sentQ.size() > 0, 1'b1);
                    if (sentQ.size() > 0) checkOutput("rxByte", rxByte, sentQ.pop_front());
                    framesDecoded++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] value);
        bit accepted = 0;
        int waitCycles = 0;
        @(negedge clk);
        txBus.TxData  = value;
        txBus.TxValid = 1'b1;
        while (!accepted && waitCycles < 2000) begin
            accepted = (txBus.TxReady === 1'b1);
            @(posedge clk);
            #1;
            waitCycles++;
            if (!accepted) @(negedge clk);
        end
        checkOutput("pushAccepted", accepted, 1'b1);
        if (accepted) begin
            lastPushCycle = cycleCount;
            sentQ.push_back(value);
        end
        txBus.TxValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((busy !== 1'b0 || fifoCount !== 3'd0) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainInTime", n < 8000, 1'b1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSequence
        int pushCycle, firstPush, framesBefore, n;
        logic [7:0] value;

        txBus.TxValid = 1'b0;
        txBus.TxData  = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        checkOn = 1;
        checkOutput("rstTxD", TxD, 1'b1);
        checkOutput("rstReady", txBus.TxReady, 1'b1);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstCount", fifoCount, 3'd0);
        reset = 1'b0;
        repeat (1000) @(negedge clk);
        checkOutput("idleTxD", TxD, 1'b1);
        checkOutput("idleBusy", busy, 1'b0);

        // Single byte: latency, bit pattern and done pulse timing.
        doneCycles.delete();
        applyStimulus(8'hA5);
        pushCycle = lastPushCycle;
        @(negedge clk);
        checkOutput("singleCountAfterPush", fifoCount, 3'd1);
        checkOutput("singleTxdBeforePop", TxD, 1'b1);
        @(negedge clk);
        checkOutput("singleTxdStart", TxD, 1'b0);
        checkOutput("singleBusy", busy, 1'b1);
        waitDrain();
        checkOutput("singleDoneCount", doneCycles.size(), 1);
        if (doneCycles.size() > 0) checkOutput("singleDoneLatency", doneCycles[0] - pushCycle, frameCycles + 1);

        // Back-to-back frames must be contiguous.
        doneCycles.delete();
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h55);
        waitDrain();
        checkOutput("b2bDoneCount", doneCycles.size(), 3);
        if (doneCycles.size() == 3) begin
            checkOutput("b2bGap1", doneCycles[1] - doneCycles[0], frameCycles);
            checkOutput("b2bGap2", doneCycles[2] - doneCycles[1], frameCycles);
        end

        // Full FIFO: one in flight, four queued, sixth waits for the next pop.
        applyStimulus(8'h11);
        firstPush = lastPushCycle;
        for (int i = 2; i <= 5; i++) applyStimulus(8'(i * 8'h11));
        checkOutput("fullCount", fifoCount, 3'd4);
        checkOutput("fullReady", txBus.TxReady, 1'b0);
        applyStimulus(8'h66);
        checkOutput("sixthAcceptCycle", lastPushCycle - firstPush, frameCycles + 2);
        waitDrain();

        // Loopback pair.
        framesBefore = framesDecoded;
        applyStimulus(8'h3C);
        applyStimulus(8'hC3);
        waitDrain();
        checkOutput("loopFrames", framesDecoded - framesBefore, 2);

        // Random bytes with random gaps, sometimes letting the line go idle.
        for (int i = 0; i < 10; i++) begin
            value = 8'($urandom_range(0, 255));
            applyStimulus(value);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(400, 700)) @(negedge clk);
            else repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        waitDrain();
        checkOutput("allFramesSeen", sentQ.size(), 0);

        // Reset during data bit 4 with two bytes queued.
        applyStimulus(8'h00);
        applyStimulus(8'h5A);
        applyStimulus(8'h81);
        n = 0;
        while (!(modelBusy && modelByte == 8'h00 && modelElapsed == 5 * bitCycles + 25) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachBit4", n < 2000, 1'b1);
        checkOutput("bit4Low", TxD, 1'b0);
        checkOutput("queuedBeforeReset", fifoCount, 3'd2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncTxD", TxD, 1'b1);
        sentQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        framesBefore = framesDecoded;
        @(negedge clk);
        checkOutput("postResetCount", fifoCount, 3'd0);
        repeat (1500) @(negedge clk);
        checkOutput("postResetBusy", busy, 1'b0);
        checkOutput("noFramesAfterReset", framesDecoded - framesBefore, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
